hsv_color_track: RTL and testbench
==================================

Name: hsv_color_track

Overview:
- Consumes the HSV pixel stream (hue/sat/val, BRAM address, valid) from the RGB-to-HSV pipeline.
- Classifies each pixel against a programmable HSV window.
- Emits a 1-bit mask write per pixel and accumulates per-frame match count and bounding box.
- Publishes one result per complete frame to the downstream overlay/tracking logic.

Parameters:
- BRAM_DEPTH, 230400, pixels per frame; address range 0..BRAM_DEPTH-1.
- FRAME_W, 640, pixels per line; FRAME_W*FRAME_H must equal BRAM_DEPTH.
- FRAME_H, 360, lines per frame.
- MIN_PIXELS, 64, minimum match count for o_found=1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  HSV pixel valid.
- i_addr  in  AW=$clog2(BRAM_DEPTH)  pixel address.
- i_hue  in  16  hue, 10.6 fixed point, 0-360.
- i_sat  in  16  saturation, 10.6, 0-100.
- i_val  in  16  value, 10.6, 0-100.
- i_hue_min, i_hue_max, i_sat_min, i_sat_max, i_val_min, i_val_max  in  16 each  window bounds, 10.6, inclusive.
- o_mask_we  out  1  mask write strobe.
- o_mask_addr  out  AW  mask write address.
- o_mask_bit  out  1  1 = pixel inside window.
- o_res_valid  out  1  one-cycle frame-result strobe.
- o_found  out  1  o_count >= MIN_PIXELS.
- o_count  out  $clog2(BRAM_DEPTH+1)  matched pixels in frame.
- o_xmin, o_xmax  out  $clog2(FRAME_W)  bounding box x.
- o_ymin, o_ymax  out  $clog2(FRAME_H)  bounding box y.
- o_frame_err  out  1  sticky; set on address discontinuity; cleared on next frame start.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; accumulators cleared.
- Stage 1 (cycle after i_valid):
  - Register inside-flag, addr, x, y.
  - Hue in window if hue_min <= hue_max and hue_min <= hue <= hue_max.
  - Hue also in window if hue_min > hue_max (wrap-around, e.g. red) and (hue >= hue_min or hue <= hue_max).
  - Sat and val use plain inclusive min <= x <= max.
  - Inside = all three true.
- Stage 2: o_mask_we/addr/bit asserted 2 cycles after the i_valid pixel; one write per valid pixel, including pixels in IDLE.
- Thresholds are latched when an addr==0 valid pixel is accepted. Changes mid-frame take effect next frame.
- Coordinates come from counters, not division:
  - addr==0 pixel is x=0, y=0.
  - Each subsequent valid pixel increments x.
  - At x==FRAME_W-1, x wraps to 0 and y increments.
- FSM states:
  - IDLE: wait for valid with addr==0 → ACCUM. Clear count; xmin/ymin to all-ones, xmax/ymax to 0; clear o_frame_err; latch thresholds.
  - ACCUM, per valid pixel with addr == previous+1: count += inside; if inside, update min/max x/y.
  - ACCUM, pixel with addr==BRAM_DEPTH-1 processed → PUBLISH.
  - ACCUM, valid addr != previous+1: set o_frame_err; go to IDLE, no publish. If that pixel has addr==0, restart ACCUM in the same cycle.
  - PUBLISH, one cycle: load o_count, o_found, bbox; pulse o_res_valid; → IDLE.
  - PUBLISH, if count==0: bbox outputs = 0, o_found=0.
- Result outputs hold their values until the next PUBLISH.
- o_res_valid fires 1 cycle after the final pixel's stage-2 mask write.
- Gaps in i_valid are allowed anywhere; the FSM and counters advance only on valid.
- A valid pixel arriving during PUBLISH is handled as in IDLE; addr==0 starts a new frame.
- Reset mid-frame: accumulation abandoned; no o_res_valid; in-flight mask writes dropped.

Test Plan:
- Full 640x360 frame, all pixels hue=120.0 (0x1E00), window hue 100-140, sat/val 0-100 → 230400 mask writes all bit=1; o_res_valid once; o_count=230400, bbox 0..639 x 0..359, o_found=1.
- Matching 10x10 block at x=200..209, y=50..59, rest hue=0 → o_count=100, xmin=200, xmax=209, ymin=50, ymax=59, o_found=1.
- Wrap window hue_min=340, hue_max=20; pixels at hue 350, 10, 180 → mask bits 1, 1, 0; boundary hue 340 and 20 → 1.
- No matches over a full frame → o_count=0, o_found=0, bbox all 0, o_res_valid pulses.
- Address jump 1000→1500 mid-frame → o_frame_err=1, no o_res_valid; next clean frame → o_frame_err=0, normal result.
- Random i_valid gaps (50% duty) plus i_rst asserted at addr 5000, then a clean frame → no result from the aborted frame; the clean frame's result matches the gap-free reference; mask latency is exactly 2 cycles.

Source files
------------

// File: rtl/hsv_color_track.sv
// rtl/hsv_color_track.sv - HSV window classifier with per-pixel mask write and per-frame count/bounding box
module hsv_color_track #(
  parameter int BRAM_DEPTH = 230400,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 360,
  parameter int MIN_PIXELS = 64,
  localparam int AW = $clog2(BRAM_DEPTH),
  localparam int CW = $clog2(BRAM_DEPTH + 1),
  localparam int XW = $clog2(FRAME_W),
  localparam int YW = $clog2(FRAME_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [AW-1:0] i_addr,
  input  logic [15:0]   i_hue,
  input  logic [15:0]   i_sat,
  input  logic [15:0]   i_val,
  input  logic [15:0]   i_hue_min,
  input  logic [15:0]   i_hue_max,
  input  logic [15:0]   i_sat_min,
  input  logic [15:0]   i_sat_max,
  input  logic [15:0]   i_val_min,
  input  logic [15:0]   i_val_max,
  output logic          o_mask_we,
  output logic [AW-1:0] o_mask_addr,
  output logic          o_mask_bit,
  output logic          o_res_valid,
  output logic          o_found,
  output logic [CW-1:0] o_count,
  output logic [XW-1:0] o_xmin,
  output logic [XW-1:0] o_xmax,
  output logic [YW-1:0] o_ymin,
  output logic [YW-1:0] o_ymax,
  output logic          o_frame_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_PUB   = 2'd2;

  localparam logic [AW-1:0] LAST_ADDR = AW'(BRAM_DEPTH - 1);
  localparam logic [XW-1:0] LAST_X    = XW'(FRAME_W - 1);

  logic [1:0]    state;
  logic [15:0]   lat_hue_min, lat_hue_max, lat_sat_min, lat_sat_max, lat_val_min, lat_val_max;
  logic [15:0]   eff_hue_min, eff_hue_max, eff_sat_min, eff_sat_max, eff_val_min, eff_val_max;
  logic          first_px, hue_ok, sat_ok, val_ok;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  logic          s1_valid, s1_inside, s1_contig;
  logic [AW-1:0] s1_addr;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  logic [CW-1:0] acc_count;
  logic [XW-1:0] acc_xmin, acc_xmax;
  logic [YW-1:0] acc_ymin, acc_ymax;
  logic          s1_start, s1_acc, s1_err;

  // The frame's first pixel is classified with the window being latched alongside it
  assign first_px    = i_valid && (i_addr == '0);
  assign eff_hue_min = first_px ? i_hue_min : lat_hue_min;
  assign eff_hue_max = first_px ? i_hue_max : lat_hue_max;
  assign eff_sat_min = first_px ? i_sat_min : lat_sat_min;
  assign eff_sat_max = first_px ? i_sat_max : lat_sat_max;
  assign eff_val_min = first_px ? i_val_min : lat_val_min;
  assign eff_val_max = first_px ? i_val_max : lat_val_max;

  always_comb begin
    hue_ok = 1'b0;
    if (eff_hue_min <= eff_hue_max)
      hue_ok = (i_hue >= eff_hue_min) && (i_hue <= eff_hue_max);
    else
      hue_ok = (i_hue >= eff_hue_min) || (i_hue <= eff_hue_max);
    sat_ok = (i_sat >= eff_sat_min) && (i_sat <= eff_sat_max);
    val_ok = (i_val >= eff_val_min) && (i_val <= eff_val_max);
  end

  // s1_x/s1_y hold the coordinates of the most recent valid pixel
  always_comb begin
    nx = '0;
    ny = '0;
    if (!first_px) begin
      if (s1_x == LAST_X) begin
        nx = '0;
        ny = s1_y + YW'(1);
      end else begin
        nx = s1_x + XW'(1);
        ny = s1_y;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid    <= 1'b0;
      s1_inside   <= 1'b0;
      s1_contig   <= 1'b0;
      s1_addr     <= '0;
      s1_x        <= '0;
      s1_y        <= '0;
      lat_hue_min <= '0;
      lat_hue_max <= '0;
      lat_sat_min <= '0;
      lat_sat_max <= '0;
      lat_val_min <= '0;
      lat_val_max <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_inside <= hue_ok && sat_ok && val_ok;
        s1_contig <= (i_addr == s1_addr + AW'(1));
        s1_addr   <= i_addr;
        s1_x      <= nx;
        s1_y      <= ny;
      end
      if (first_px) begin
        lat_hue_min <= i_hue_min;
        lat_hue_max <= i_hue_max;
        lat_sat_min <= i_sat_min;
        lat_sat_max <= i_sat_max;
        lat_val_min <= i_val_min;
        lat_val_max <= i_val_max;
      end
    end
  end

  assign s1_err   = s1_valid && (state == ST_ACCUM) && !s1_contig;
  assign s1_acc   = s1_valid && (state == ST_ACCUM) && s1_contig;
  assign s1_start = s1_valid && (s1_addr == '0) && ((state != ST_ACCUM) || !s1_contig);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      o_mask_we   <= 1'b0;
      o_mask_addr <= '0;
      o_mask_bit  <= 1'b0;
      o_res_valid <= 1'b0;
      o_found     <= 1'b0;
      o_count     <= '0;
      o_xmin      <= '0;
      o_xmax      <= '0;
      o_ymin      <= '0;
      o_ymax      <= '0;
      o_frame_err <= 1'b0;
      acc_count   <= '0;
      acc_xmin    <= '0;
      acc_xmax    <= '0;
      acc_ymin    <= '0;
      acc_ymax    <= '0;
    end else begin
      o_mask_we   <= s1_valid;
      o_mask_addr <= s1_addr;
      o_mask_bit  <= s1_valid && s1_inside;
      o_res_valid <= 1'b0;

      if (state == ST_PUB) begin
        o_res_valid <= 1'b1;
        o_count     <= acc_count;
        o_found     <= (acc_count >= CW'(MIN_PIXELS));
        o_xmin      <= (acc_count == '0) ? '0 : acc_xmin;
        o_xmax      <= (acc_count == '0) ? '0 : acc_xmax;
        o_ymin      <= (acc_count == '0) ? '0 : acc_ymin;
        o_ymax      <= (acc_count == '0) ? '0 : acc_ymax;
        state       <= ST_IDLE;
      end

      if (s1_err) begin
        o_frame_err <= 1'b1;
        state       <= ST_IDLE;
      end

      // A discontinuity that lands on address 0 keeps the error flag but restarts accumulation
      if (s1_start) begin
        acc_count <= CW'(s1_inside);
        acc_xmin  <= s1_inside ? s1_x : '1;
        acc_xmax  <= s1_inside ? s1_x : '0;
        acc_ymin  <= s1_inside ? s1_y : '1;
        acc_ymax  <= s1_inside ? s1_y : '0;
        if (!s1_err)
          o_frame_err <= 1'b0;
        state <= ST_ACCUM;
      end else if (s1_acc) begin
        acc_count <= acc_count + CW'(s1_inside);
        if (s1_inside) begin
          if (s1_x < acc_xmin) acc_xmin <= s1_x;
          if (s1_x > acc_xmax) acc_xmax <= s1_x;
          if (s1_y < acc_ymin) acc_ymin <= s1_y;
          if (s1_y > acc_ymax) acc_ymax <= s1_y;
        end
        if (s1_addr == LAST_ADDR)
          state <= ST_PUB;
      end
    end
  end

endmodule

// File: tb/tb_hsv_color_track.sv
// tb/tb_hsv_color_track.sv - randomized self-checking bench for hsv_color_track against a frame-level reference model
module tb_hsv_color_track;

  localparam int W    = 32;
  localparam int H    = 16;
  localparam int D    = W * H;
  localparam int MINP = 64;
  localparam int AW   = $clog2(D);
  localparam int CW   = $clog2(D + 1);
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [15:0]   i_hue = '0, i_sat = '0, i_val = '0;
  logic [15:0]   i_hue_min = '0, i_hue_max = '0, i_sat_min = '0, i_sat_max = '0, i_val_min = '0, i_val_max = '0;
  logic          o_mask_we, o_mask_bit, o_res_valid, o_found, o_frame_err;
  logic [AW-1:0] o_mask_addr;
  logic [CW-1:0] o_count;
  logic [XW-1:0] o_xmin, o_xmax;
  logic [YW-1:0] o_ymin, o_ymax;

  hsv_color_track #(.BRAM_DEPTH(D), .FRAME_W(W), .FRAME_H(H), .MIN_PIXELS(MINP)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_addr(i_addr),
    .i_hue(i_hue), .i_sat(i_sat), .i_val(i_val),
    .i_hue_min(i_hue_min), .i_hue_max(i_hue_max), .i_sat_min(i_sat_min),
    .i_sat_max(i_sat_max), .i_val_min(i_val_min), .i_val_max(i_val_max),
    .o_mask_we(o_mask_we), .o_mask_addr(o_mask_addr), .o_mask_bit(o_mask_bit),
    .o_res_valid(o_res_valid), .o_found(o_found), .o_count(o_count),
    .o_xmin(o_xmin), .o_xmax(o_xmax), .o_ymin(o_ymin), .o_ymax(o_ymax),
    .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { int addr; bit b; int unsigned due; } mask_t;
  typedef struct { int cnt; int xmin; int xmax; int ymin; int ymax; bit found; int unsigned due; } res_t;

  mask_t mq[$];
  res_t  rq[$];
  res_t  eq[$];

  logic [15:0] ph[D];
  logic [15:0] ps[D];
  logic [15:0] pv[D];
  logic [15:0] lw[6];
  int unsigned last_k;

  function automatic bit in_win(input logic [15:0] h, input logic [15:0] s, input logic [15:0] v);
    bit hk;
    if (lw[0] <= lw[1]) hk = (h >= lw[0]) && (h <= lw[1]);
    else                hk = (h >= lw[0]) || (h <= lw[1]);
    return hk && (s >= lw[2]) && (s <= lw[3]) && (v >= lw[4]) && (v <= lw[5]);
  endfunction

  task automatic set_win(input int hmin, input int hmax, input int smin, input int smax, input int vmin, input int vmax);
    i_hue_min = 16'(hmin * 64);
    i_hue_max = 16'(hmax * 64);
    i_sat_min = 16'(smin * 64);
    i_sat_max = 16'(smax * 64);
    i_val_min = 16'(vmin * 64);
    i_val_max = 16'(vmax * 64);
  endtask

  task automatic fill_sv();
    for (int a = 0; a < D; a++) begin
      ps[a] = 16'($urandom_range(0, 6400));
      pv[a] = 16'($urandom_range(0, 6400));
    end
  endtask

  task automatic fill_block(input int x0, input int x1, input int y0, input int y1);
    fill_sv();
    for (int a = 0; a < D; a++)
      ph[a] = ((a % W) >= x0 && (a % W) <= x1 && (a / W) >= y0 && (a / W) <= y1) ? 16'(120 * 64) : 16'd0;
  endtask

  task automatic fill_const(input int hdeg);
    fill_sv();
    for (int a = 0; a < D; a++) ph[a] = 16'(hdeg * 64);
  endtask

  task automatic fill_random();
    fill_sv();
    for (int a = 0; a < D; a++) ph[a] = 16'($urandom_range(0, 360 * 64));
  endtask

  task automatic fill_wrap();
    int wl[8] = '{350, 10, 180, 340, 20, 339, 21, 0};
    int k;
    fill_sv();
    for (int a = 0; a < D; a++) begin
      k = $urandom_range(0, 7);
      ph[a] = (k < 7) ? 16'(wl[k] * 64) : 16'($urandom_range(0, 360 * 64));
    end
  endtask

  task automatic send(input int a, input int gap_pct, output bit b);
    int g = 0;
    while (gap_pct > 0 && g < 4 && $urandom_range(0, 99) < gap_pct) begin
      @(posedge clk); #1;
      g++;
    end
    if (a == 0) begin
      lw[0] = i_hue_min; lw[1] = i_hue_max;
      lw[2] = i_sat_min; lw[3] = i_sat_max;
      lw[4] = i_val_min; lw[5] = i_val_max;
    end
    i_valid = 1'b1;
    i_addr  = AW'(a);
    i_hue   = ph[a];
    i_sat   = ps[a];
    i_val   = pv[a];
    b = in_win(ph[a], ps[a], pv[a]);
    mq.push_back('{addr: a, b: b, due: cyc + 2});
    last_k = cyc;
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    rst = 1'b1;
    while (mq.size() > 0 && mq[mq.size() - 1].due > cyc) void'(mq.pop_back());
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference: frame statistics from addresses by division, independent of arrival timing
  task automatic run_frame(input int gap_pct, input int jump_at, input int jump_to, input int chg_at, input int abort_at);
    int a = 0;
    int cnt = 0, xmn = W, xmx = -1, ymn = H, ymx = -1;
    bit clean = 1'b1;
    bit b;
    while (a < D) begin
      if (a == abort_at) begin
        do_reset();
        return;
      end
      if (a == chg_at) begin
        i_hue_min = 16'($urandom); i_hue_max = 16'($urandom);
        i_sat_min = 16'($urandom); i_sat_max = 16'($urandom);
        i_val_min = 16'($urandom); i_val_max = 16'($urandom);
      end
      send(a, gap_pct, b);
      if (b) begin
        cnt++;
        if (a % W < xmn) xmn = a % W;
        if (a % W > xmx) xmx = a % W;
        if (a / W < ymn) ymn = a / W;
        if (a / W > ymx) ymx = a / W;
      end
      if (a == jump_at) begin
        a = jump_to;
        clean = 1'b0;
      end else begin
        a++;
      end
    end
    if (clean) begin
      if (cnt == 0) eq.push_back('{cnt: 0, xmin: 0, xmax: 0, ymin: 0, ymax: 0, found: 1'b0, due: last_k + 3});
      else eq.push_back('{cnt: cnt, xmin: xmn, xmax: xmx, ymin: ymn, ymax: ymx, found: (cnt >= MINP), due: last_k + 3});
    end
  endtask

  task automatic check_results(input string tag);
    res_t r, e;
    bit any = 1'b0;
    for (int i = 0; i < 40 && rq.size() < eq.size(); i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk({tag, "_nres"}, rq.size(), eq.size());
    while (rq.size() > 0 && eq.size() > 0) begin
      r = rq.pop_front();
      e = eq.pop_front();
      any = 1'b1;
      chk({tag, "_count"}, r.cnt, e.cnt);
      chk({tag, "_found"}, r.found, e.found);
      chk({tag, "_xmin"}, r.xmin, e.xmin);
      chk({tag, "_xmax"}, r.xmax, e.xmax);
      chk({tag, "_ymin"}, r.ymin, e.ymin);
      chk({tag, "_ymax"}, r.ymax, e.ymax);
      chk({tag, "_res_cycle"}, r.due, e.due);
    end
    if (any) chk({tag, "_hold_count"}, o_count, e.cnt);
    rq.delete();
    eq.delete();
    chk({tag, "_mask_pending"}, mq.size(), 0);
    mq.delete();
  endtask

  initial begin : mask_mon
    mask_t me;
    forever begin
      @(negedge clk);
      if (o_mask_we === 1'b1) begin
        if (mq.size() == 0) begin
          chk("mask_unexpected_we", o_mask_we, 0);
        end else begin
          me = mq.pop_front();
          chk("mask_addr", o_mask_addr, me.addr);
          chk("mask_bit", o_mask_bit, me.b);
          chk("mask_latency", cyc, me.due);
        end
      end else if (mq.size() > 0 && mq[0].due <= cyc) begin
        chk("mask_missing_we", o_mask_we, 1);
        void'(mq.pop_front());
      end
    end
  end

  initial begin : res_mon
    forever begin
      @(negedge clk);
      if (o_res_valid === 1'b1)
        rq.push_back('{cnt: int'(o_count), xmin: int'(o_xmin), xmax: int'(o_xmax),
                       ymin: int'(o_ymin), ymax: int'(o_ymax), found: o_found, due: cyc});
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mask_we", o_mask_we, 0);
    chk("reset_res_valid", o_res_valid, 0);
    chk("reset_found", o_found, 0);
    chk("reset_count", o_count, 0);
    chk("reset_bbox", {o_xmin, o_xmax, o_ymin, o_ymax}, 0);
    chk("reset_frame_err", o_frame_err, 0);
    @(posedge clk); #1;

    set_win(100, 140, 0, 100, 0, 100);
    fill_const(120);
    run_frame(0, -1, -1, -1, -1);
    check_results("full");
    chk("full_count_total", o_count, D);
    chk("full_bbox", {o_xmin, o_xmax, o_ymin, o_ymax}, {XW'(0), XW'(W - 1), YW'(0), YW'(H - 1)});

    fill_block(10, 19, 3, 12);
    run_frame(0, -1, -1, 150, -1);
    check_results("block100");
    chk("block100_found", o_found, 1);

    set_win(100, 140, 0, 100, 0, 100);
    fill_block(5, 13, 2, 8);
    run_frame(0, -1, -1, -1, -1);
    fill_block(20, 27, 6, 13);
    run_frame(0, -1, -1, -1, -1);
    check_results("b2b_63_64");

    set_win(340, 20, 10, 90, 0, 100);
    fill_wrap();
    run_frame(30, -1, -1, -1, -1);
    check_results("wrap");

    set_win(100, 140, 0, 100, 0, 100);
    fill_const(0);
    run_frame(10, -1, -1, -1, -1);
    check_results("nomatch");
    chk("nomatch_count", o_count, 0);

    set_win(60, 180, 20, 100, 30, 100);
    fill_random();
    run_frame(0, 200, 300, -1, -1);
    check_results("jump");
    chk("jump_frame_err", o_frame_err, 1);

    fill_random();
    run_frame(20, -1, -1, -1, -1);
    check_results("after_jump");
    chk("after_jump_frame_err", o_frame_err, 0);

    fill_random();
    run_frame(50, -1, -1, -1, 300);
    check_results("abort");
    chk("abort_count_cleared", o_count, 0);
    chk("abort_found_cleared", o_found, 0);

    set_win(200, 40, 0, 80, 10, 100);
    fill_random();
    run_frame(50, -1, -1, -1, -1);
    check_results("gap_clean");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
